stream_patchifier: RTL and testbench
====================================

STREAM_PATCHIFIER -- requirements
Module: stream_patchifier

Interface
REQ-001 SHALL have parameter CHANNEL_SIZE, 8, bits per channel.
REQ-002 SHALL have parameter NUM_CHANNELS, 3, channels per pixel; PIXEL_WIDTH = CHANNEL_SIZE*NUM_CHANNELS.
REQ-003 SHALL have parameter IMG_WIDTH, 8, pixels per image row; multiple of PATCH_SIZE.
REQ-004 SHALL have parameter IMG_HEIGHT, 8, rows per image; multiple of PATCH_SIZE.
REQ-005 SHALL have parameter PATCH_SIZE, 2, patch edge in pixels; PIR = IMG_WIDTH/PATCH_SIZE, NP = PIR*(IMG_HEIGHT/PATCH_SIZE), PV = PATCH_SIZE^2.
REQ-006 Ports SHALL be: clk (input, 1, clock); reset (input, 1, synchronous, active-high).
REQ-007 start  input  1  begin one image; honoured only in IDLE.
REQ-008 in_valid  input  1 / in_ready  output  1  raster-order pixel stream handshake.
REQ-009 in_pixel  input  PIXEL_WIDTH  pixel, channel 0 in LSBs.
REQ-010 out_valid  output  1 / out_ready  input  1  patch-order pixel stream handshake.
REQ-011 out_pixel  output  PIXEL_WIDTH  current patch element.
REQ-012 out_patch_idx  output  max(1,clog2(NP))  patch number, row-major over patch grid.
REQ-013 out_pos_idx  output  max(1,clog2(PV))  position within patch, row-major.
REQ-014 out_patch_last  output  1  high on element PV-1 of each patch.
REQ-015 out_image_last  output  1  high on final element of patch NP-1.
REQ-016 busy  output  1  high when state != IDLE; done  output  1  one-cycle pulse after image completes.
REQ-017 state  output  2  IDLE=00, FILL=01, DRAIN=10.

Function
REQ-018 Internal strip buffer SHALL hold PATCH_SIZE x IMG_WIDTH pixels (single bank; fill and drain do not overlap).
REQ-019 IDLE: in_ready=0, out_valid=0; start=1 -> FILL next cycle, strip counter=0.
REQ-020 FILL: in_ready=1; each in_valid&in_ready writes buf[row][col], col increments, wraps at IMG_WIDTH with row increment.
REQ-021 Acceptance of pixel (PATCH_SIZE-1, IMG_WIDTH-1) of strip SHALL move to DRAIN next cycle; row/col clear to 0.
REQ-022 DRAIN: in_ready=0, out_valid=1; order: patch column pc 0..PIR-1, within patch row r 0..P-1, col c 0..P-1.
REQ-023 out_pixel = buf[r][pc*P+c]; out_patch_idx = strip*PIR+pc; out_pos_idx = r*P+c.
REQ-024 Counters SHALL advance only on out_valid&out_ready; all out_* SHALL hold stable while out_valid&!out_ready.
REQ-025 Final DRAIN handshake of a strip: strip<IMG_HEIGHT/P-1 -> FILL, strip+1; else -> IDLE, done=1 next cycle.
REQ-026 Latency: first out_valid of a strip SHALL be the cycle after its last input accept.
REQ-027 start while busy SHALL be ignored; in_valid outside FILL SHALL be ignored (not consumed).
REQ-028 Index arithmetic SHALL be unsigned, zero-extended to port width; no wrap beyond NP-1/PV-1.

Reset
REQ-029 reset SHALL force state=IDLE, all counters=0, in_ready=0, out_valid=0, out_patch_last=0, out_image_last=0, busy=0, done=0 on the next clk edge.
REQ-030 Reset mid-FILL or mid-DRAIN SHALL abort the image; no further outputs until a new start; buffer contents need not be cleared.
REQ-031 Reset SHALL take priority over start and all handshakes in the same cycle.

Verification
REQ-032 4x4, P=2, pixels = raster index 0..15, out_ready=1 -> out_pixel 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15; patch_idx 0..3; done one cycle after value 15.
REQ-033 Same image, out_ready toggling 1/0 each cycle -> identical sequence, outputs stable during stalls, out_patch_last on pos_idx 3 only.
REQ-034 in_valid gaps (every third cycle low) in FILL -> same output sequence; in_ready=0 throughout DRAIN.
REQ-035 reset asserted after 6th input accept, then new start with fresh image -> first output equals new image's pixel 0, patch_idx 0.
REQ-036 start pulsed during DRAIN, and in_valid high in IDLE -> no state change, no pixel consumed.
REQ-037 IMG_WIDTH=8, IMG_HEIGHT=4, P=4, NUM_CHANNELS=1 -> 2 patches of 16; patch 1 pos 0 = pixel 4, out_image_last on pixel 31.

Source files
------------

// File: rtl/stream_patchifier.sv
// Purpose: buffers PATCH_SIZE raster rows of an image, then replays them patch by patch, each patch in row-major order.
// Latency: the first output of a strip is valid the cycle after that strip's last pixel is accepted.
// Backpressure: input and output phases never overlap; out_* hold steady while out_valid && !out_ready.
module stream_patchifier #(
    parameter  int CHANNEL_SIZE = 8,
    parameter  int NUM_CHANNELS = 3,
    parameter  int IMG_WIDTH    = 8,
    parameter  int IMG_HEIGHT   = 8,
    parameter  int PATCH_SIZE   = 2,
    localparam int PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS,
    localparam int PIR          = IMG_WIDTH / PATCH_SIZE,
    localparam int NUM_STRIPS   = IMG_HEIGHT / PATCH_SIZE,
    localparam int NP           = PIR * NUM_STRIPS,
    localparam int PV           = PATCH_SIZE * PATCH_SIZE,
    localparam int PATCH_IDX_W  = (NP > 1) ? $clog2(NP) : 1,
    localparam int POS_IDX_W    = (PV > 1) ? $clog2(PV) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic [PATCH_IDX_W-1:0] out_patch_idx,
    output logic [POS_IDX_W-1:0]   out_pos_idx,
    output logic                   out_patch_last,
    output logic                   out_image_last,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FILL  = 2'b01,
        S_DRAIN = 2'b10
    } state_t;

    state_t                 cur_state;

    // Single-bank strip store: PATCH_SIZE rows of a full image row each.
    logic [PIXEL_WIDTH-1:0] strip_buf [PATCH_SIZE][IMG_WIDTH];

    // Fill-side write pointer.
    logic [ROW_W-1:0]       wr_row;
    logic [COL_W-1:0]       wr_col;

    // Drain-side read pointer: row/col inside the patch plus the patch's left column.
    logic [ROW_W-1:0]       rd_row;
    logic [ROW_W-1:0]       rd_c;
    logic [COL_W-1:0]       col_base;
    logic [COL_W-1:0]       rd_col;

    // Patch index doubles as strip*PIR + patch column, so no separate strip counter is needed.
    logic [PATCH_IDX_W-1:0] patch_idx;
    logic [POS_IDX_W-1:0]   pos_idx;
    logic                   done_q;

    logic                   in_fire;
    logic                   out_fire;
    logic                   wr_col_last;
    logic                   wr_row_last;
    logic                   rd_c_last;
    logic                   rd_row_last;
    logic                   patch_end;
    logic                   last_in_row;
    logic                   is_final_patch;

    assign in_ready       = (cur_state == S_FILL);
    assign out_valid      = (cur_state == S_DRAIN);
    assign in_fire        = in_valid & in_ready;
    assign out_fire       = out_valid & out_ready;

    assign wr_col_last    = (wr_col == COL_W'(IMG_WIDTH - 1));
    assign wr_row_last    = (wr_row == ROW_W'(PATCH_SIZE - 1));
    assign rd_c_last      = (rd_c == ROW_W'(PATCH_SIZE - 1));
    assign rd_row_last    = (rd_row == ROW_W'(PATCH_SIZE - 1));
    assign patch_end      = rd_c_last & rd_row_last;
    assign last_in_row    = (col_base == COL_W'(IMG_WIDTH - PATCH_SIZE));
    assign is_final_patch = (patch_idx == PATCH_IDX_W'(NP - 1));

    // The read pointer only moves on an output handshake, so the read data is stable across stalls.
    assign rd_col         = col_base + COL_W'(rd_c);
    assign out_pixel      = strip_buf[rd_row][rd_col];
    assign out_patch_idx  = patch_idx;
    assign out_pos_idx    = pos_idx;
    assign out_patch_last = out_valid & patch_end;
    assign out_image_last = out_valid & patch_end & is_final_patch;
    assign busy           = (cur_state != S_IDLE);
    assign done           = done_q;
    assign state          = cur_state;

    // Capture accepted raster pixels into the strip buffer (contents are never cleared).
    always_ff @(posedge clk) begin
        if (in_fire) begin
            strip_buf[wr_row][wr_col] <= in_pixel;
        end
    end

    // Sequencing: IDLE -> FILL one strip -> DRAIN its patches -> next strip or back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_IDLE;
            wr_row    <= '0;
            wr_col    <= '0;
            rd_row    <= '0;
            rd_c      <= '0;
            col_base  <= '0;
            patch_idx <= '0;
            pos_idx   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (cur_state)
                S_IDLE: begin
                    if (start) begin
                        cur_state <= S_FILL;
                        wr_row    <= '0;
                        wr_col    <= '0;
                        rd_row    <= '0;
                        rd_c      <= '0;
                        col_base  <= '0;
                        patch_idx <= '0;
                        pos_idx   <= '0;
                    end
                end

                S_FILL: begin
                    if (in_fire) begin
                        if (wr_col_last) begin
                            wr_col <= '0;
                            if (wr_row_last) begin
                                wr_row    <= '0;
                                cur_state <= S_DRAIN;
                            end else begin
                                wr_row <= wr_row + 1'b1;
                            end
                        end else begin
                            wr_col <= wr_col + 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (out_fire) begin
                        if (!rd_c_last) begin
                            rd_c    <= rd_c + 1'b1;
                            pos_idx <= pos_idx + 1'b1;
                        end else begin
                            rd_c <= '0;
                            if (!rd_row_last) begin
                                rd_row  <= rd_row + 1'b1;
                                pos_idx <= pos_idx + 1'b1;
                            end else begin
                                // Patch complete: step to the next patch, strip, or finish the image.
                                rd_row  <= '0;
                                pos_idx <= '0;
                                if (is_final_patch) begin
                                    patch_idx <= '0;
                                    col_base  <= '0;
                                    cur_state <= S_IDLE;
                                    done_q    <= 1'b1;
                                end else begin
                                    patch_idx <= patch_idx + 1'b1;
                                    if (last_in_row) begin
                                        col_base  <= '0;
                                        cur_state <= S_FILL;
                                    end else begin
                                        col_base <= col_base + COL_W'(PATCH_SIZE);
                                    end
                                end
                            end
                        end
                    end
                end

                default: begin
                    cur_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_patchifier.sv
// Bench for stream_patchifier: a 4x4 / P=2 / 3-channel instance driven by tables and random
// traffic against a patch-order model, plus an 8x4 / P=4 / 1-channel instance.
module tb_stream_patchifier;

    localparam int AW = 4, AH = 4, AP = 2, APW = 24, APV = AP * AP, ATOT = AW * AH;
    localparam int BW = 8, BH = 4, BP = 4, BPW = 8, BPV = BP * BP, BTOT = BW * BH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A signals
    logic           start_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [APW-1:0] in_pixel_a, out_pixel_a;
    logic [1:0]     out_patch_idx_a, out_pos_idx_a, state_a;
    logic           out_patch_last_a, out_image_last_a, busy_a, done_a;

    // Instance B signals
    logic           start_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [BPW-1:0] in_pixel_b, out_pixel_b;
    logic [0:0]     out_patch_idx_b;
    logic [3:0]     out_pos_idx_b;
    logic [1:0]     state_b;
    logic           out_patch_last_b, out_image_last_b, busy_b, done_b;

    stream_patchifier #(
        .CHANNEL_SIZE(8), .NUM_CHANNELS(3), .IMG_WIDTH(AW), .IMG_HEIGHT(AH), .PATCH_SIZE(AP)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_pixel(in_pixel_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pixel(out_pixel_a),
        .out_patch_idx(out_patch_idx_a), .out_pos_idx(out_pos_idx_a),
        .out_patch_last(out_patch_last_a), .out_image_last(out_image_last_a),
        .busy(busy_a), .done(done_a), .state(state_a)
    );

    stream_patchifier #(
        .CHANNEL_SIZE(8), .NUM_CHANNELS(1), .IMG_WIDTH(BW), .IMG_HEIGHT(BH), .PATCH_SIZE(BP)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pixel(in_pixel_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pixel(out_pixel_b),
        .out_patch_idx(out_patch_idx_b), .out_pos_idx(out_pos_idx_b),
        .out_patch_last(out_patch_last_b), .out_image_last(out_image_last_b),
        .busy(busy_b), .done(done_b), .state(state_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [APW-1:0] in_pix;
        logic [APW-1:0] pix;
        int             patch;
        int             pos;
        bit             plast;
        bit             ilast;
    } vec_t;

    vec_t           tbl [ATOT];
    int             seq [ATOT] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    logic [APW-1:0] img_a   [ATOT];
    logic [APW-1:0] exp_pix [ATOT];
    int             exp_patch [ATOT];
    int             exp_pos   [ATOT];
    logic [APW-1:0] cap_pix [ATOT];
    int             cap_patch [ATOT];
    int             cap_pos   [ATOT];
    bit             cap_pl    [ATOT];
    bit             cap_il    [ATOT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Patch-order expectation straight from the image geometry.
    task automatic build_model_a();
        int k;
        k = 0;
        for (int s = 0; s < AH / AP; s++)
            for (int pc = 0; pc < AW / AP; pc++)
                for (int r = 0; r < AP; r++)
                    for (int c = 0; c < AP; c++) begin
                        exp_pix[k]   = img_a[(s * AP + r) * AW + pc * AP + c];
                        exp_patch[k] = s * (AW / AP) + pc;
                        exp_pos[k]   = r * AP + c;
                        k++;
                    end
    endtask

    task automatic random_image_a();
        for (int i = 0; i < ATOT; i++) img_a[i] = APW'($urandom);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_state"}, state_a, 0);
        check({tag, "_flags"}, {in_ready_a, out_valid_a, out_patch_last_a, out_image_last_a, busy_a, done_a}, 0);
        check({tag, "_idx"}, {out_patch_idx_a, out_pos_idx_a}, 0);
    endtask

    // One full image on instance A. vmode: 0 always valid, 1 every third cycle low, 2 random.
    // rmode: 0 always ready, 1 toggling, 2 random. spam: random start pulses while busy.
    task automatic run_a(input int vmode, input int rmode, input bit spam);
        int in_idx, out_idx, cyc;
        bit exp_done, fin, exp_ov, prev_stall;
        logic [29:0] prev_vec;
        in_idx = 0; out_idx = 0; cyc = 0;
        exp_done = 0; fin = 0; exp_ov = 0; prev_stall = 0; prev_vec = '0;
        build_model_a();
        start_a = 1'b1; in_valid_a = 1'b0; out_ready_a = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0;
        while (!fin && cyc < 3000) begin
            if (exp_done) begin
                check("done_pulse", done_a, 1);
                check("idle_after_done", {busy_a, state_a, out_valid_a}, 0);
                fin = 1;
            end else if (done_a) begin
                check("done_early", done_a, 0);
            end
            if (exp_ov) begin
                check("first_out_latency", out_valid_a, 1);
                exp_ov = 0;
            end
            if (prev_stall) begin
                check("stall_valid_hold", out_valid_a, 1);
                check("stall_out_hold",
                      {out_pixel_a, out_patch_idx_a, out_pos_idx_a, out_patch_last_a, out_image_last_a}, prev_vec);
            end
            if (out_valid_a) check("in_ready_in_drain", in_ready_a, 0);
            if (!fin) begin
                case (vmode)
                    0:       in_valid_a = (in_idx < ATOT);
                    1:       in_valid_a = (in_idx < ATOT) && (cyc % 3 != 2);
                    default: in_valid_a = (in_idx < ATOT) && ($urandom_range(3) != 0);
                endcase
                in_pixel_a = (in_idx < ATOT) ? img_a[in_idx] : '0;
                case (rmode)
                    0:       out_ready_a = 1'b1;
                    1:       out_ready_a = (cyc % 2 == 0);
                    default: out_ready_a = ($urandom_range(1) == 1);
                endcase
                start_a = spam ? ($urandom_range(1) == 1) : 1'b0;
                if (in_valid_a && in_ready_a) begin
                    in_idx++;
                    if (in_idx % (AP * AW) == 0) exp_ov = 1;
                end
                if (out_valid_a && out_ready_a) begin
                    check("out_pixel", out_pixel_a, exp_pix[out_idx]);
                    check("out_patch_idx", out_patch_idx_a, exp_patch[out_idx]);
                    check("out_pos_idx", out_pos_idx_a, exp_pos[out_idx]);
                    check("out_patch_last", out_patch_last_a, exp_pos[out_idx] == APV - 1);
                    check("out_image_last", out_image_last_a, out_idx == ATOT - 1);
                    cap_pix[out_idx]   = out_pixel_a;
                    cap_patch[out_idx] = out_patch_idx_a;
                    cap_pos[out_idx]   = out_pos_idx_a;
                    cap_pl[out_idx]    = out_patch_last_a;
                    cap_il[out_idx]    = out_image_last_a;
                    out_idx++;
                    if (out_idx == ATOT) exp_done = 1;
                end
                prev_stall = out_valid_a && !out_ready_a;
                prev_vec   = {out_pixel_a, out_patch_idx_a, out_pos_idx_a, out_patch_last_a, out_image_last_a};
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("image_finished", fin, 1);
        check("inputs_consumed", in_idx, ATOT);
        start_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    endtask

    // Start an image, stop after n_acc accepts and n_out outputs, then reset with all inputs active.
    task automatic abort_a(input int n_acc, input int n_out, input string tag);
        int acc, outs, cyc;
        acc = 0; outs = 0; cyc = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        while ((acc < n_acc || outs < n_out) && cyc < 200) begin
            in_valid_a  = (acc < n_acc);
            in_pixel_a  = APW'($urandom);
            out_ready_a = 1'b1;
            if (in_valid_a && in_ready_a) acc++;
            if (out_valid_a) outs++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_progress"}, {acc[7:0], outs[7:0]}, {n_acc[7:0], n_out[7:0]});
        reset = 1'b1; start_a = 1'b1; in_valid_a = 1'b1; out_ready_a = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
        check_reset_a(tag);
    endtask

    // In IDLE with in_valid held high: nothing may be consumed and the state must not move.
    task automatic idle_hold_a();
        for (int i = 0; i < 3; i++) begin
            in_valid_a = 1'b1; in_pixel_a = APW'($urandom); out_ready_a = 1'b1;
            @(posedge clk); #1;
            check("idle_hold_state", {state_a, in_ready_a, out_valid_a}, 0);
        end
        in_valid_a = 1'b0; out_ready_a = 1'b0;
    endtask

    task automatic run_b();
        int in_idx, out_idx, cyc, patch, pos, pix;
        bit exp_done, fin;
        in_idx = 0; out_idx = 0; cyc = 0; exp_done = 0; fin = 0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        while (!fin && cyc < 500) begin
            if (exp_done) begin
                check("b_done_pulse", done_b, 1);
                fin = 1;
            end else begin
                in_valid_b  = (in_idx < BTOT);
                in_pixel_b  = BPW'(in_idx);
                out_ready_b = 1'b1;
                if (in_valid_b && in_ready_b) in_idx++;
                if (out_valid_b && out_ready_b) begin
                    patch = out_idx / BPV;
                    pos   = out_idx % BPV;
                    pix   = (pos / BP) * BW + patch * BP + (pos % BP);
                    check("b_out_pixel", out_pixel_b, pix);
                    check("b_out_patch_idx", out_patch_idx_b, patch);
                    check("b_out_pos_idx", out_pos_idx_b, pos);
                    check("b_out_patch_last", out_patch_last_b, pos == BPV - 1);
                    check("b_out_image_last", out_image_last_b, out_idx == BTOT - 1);
                    out_idx++;
                    if (out_idx == BTOT) exp_done = 1;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("b_finished", fin, 1);
        in_valid_b = 1'b0; out_ready_b = 1'b0;
    endtask

    initial begin
        start_a = 0; in_valid_a = 0; out_ready_a = 0; in_pixel_a = '0;
        start_b = 0; in_valid_b = 0; out_ready_b = 0; in_pixel_b = '0;
        for (int i = 0; i < ATOT; i++) begin
            tbl[i].in_pix = APW'(i);
            tbl[i].pix    = APW'(seq[i]);
            tbl[i].patch  = i / APV;
            tbl[i].pos    = i % APV;
            tbl[i].plast  = (i % APV == APV - 1);
            tbl[i].ilast  = (i == ATOT - 1);
        end

        // Reset state with start asserted: reset wins.
        start_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_a("reset");
        check("b_reset", {state_b, in_ready_b, out_valid_b, busy_b, done_b}, 0);
        reset = 1'b0; start_a = 1'b0;
        @(posedge clk); #1;

        // Raster-index image, full-rate output, compared to the table.
        for (int i = 0; i < ATOT; i++) img_a[i] = tbl[i].in_pix;
        run_a(0, 0, 0);
        for (int i = 0; i < ATOT; i++) begin
            check("tbl_pixel", cap_pix[i], tbl[i].pix);
            check("tbl_patch", cap_patch[i], tbl[i].patch);
            check("tbl_pos", cap_pos[i], tbl[i].pos);
            check("tbl_last", {cap_pl[i], cap_il[i]}, {tbl[i].plast, tbl[i].ilast});
        end

        // Same image with toggling out_ready, then with input gaps.
        run_a(0, 1, 0);
        run_a(1, 0, 0);

        // Abort mid-fill, then a fresh image.
        abort_a(6, 0, "abort_fill");
        idle_hold_a();
        random_image_a();
        run_a(0, 0, 0);

        // Abort mid-drain, then a fresh image with start spam during busy.
        abort_a(AP * AW, 2, "abort_drain");
        idle_hold_a();
        random_image_a();
        run_a(2, 2, 1);

        // Randomized images and traffic.
        for (int t = 0; t < 8; t++) begin
            random_image_a();
            run_a($urandom_range(2), $urandom_range(2), 1'($urandom_range(1)));
        end

        // Wide-patch, single-channel geometry.
        run_b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
